// File: rtl/down_cnt_tff.sv
// Loadable, enable-gated down counter/timer built on a T-flip-flop borrow chain.
// Terminal count gives a one-cycle TC pulse, then the counter stops (MODE=0) or reloads (MODE=1).
module down_cnt_tff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             E,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             MODE,
  output logic [WIDTH-1:0] q,
  output logic             TC,
  output logic             BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic             tc, tc_next;
  logic             count_en;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] decremented;

  // Gating on a nonzero count keeps the borrow chain from wrapping 0 -> all-ones.
  assign count_en = (state == RUN) && E && (count != '0);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_borrow
      if (gi == 0) begin : g_lsb
        assign toggle[gi] = count_en;
      end else begin : g_upper
        assign toggle[gi] = count_en && (count[gi-1:0] == '0);
      end
    end
  endgenerate

  assign decremented = count ^ toggle;

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    tc_next     = 1'b0;

    if (LD) begin
      count_next  = D;
      reload_next = D;
      state_next  = (D != '0) ? RUN : IDLE;
    end else if (count_en) begin
      if (count == WIDTH'(1)) begin
        tc_next = 1'b1;
        if (MODE) begin
          count_next = reload;
        end else begin
          count_next = decremented;
          state_next = IDLE;
        end
      end else begin
        count_next = decremented;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      tc     <= tc_next;
    end
  end

  assign q    = count;
  assign TC   = tc;
  assign BUSY = (state == RUN);

endmodule

// File: tb/tb_down_cnt_tff.sv
// Scoreboard bench for down_cnt_tff: stimulus pushes expected {q,TC,BUSY}, monitor pops after each edge.
module tb_down_cnt_tff;

  localparam int unsigned W = 4;

  logic         CK = 1'b0;
  logic         CLR = 1'b1;
  logic         E = 1'b0;
  logic         LD = 1'b0;
  logic [W-1:0] D = '0;
  logic         MODE = 1'b0;
  logic [W-1:0] q;
  logic         TC;
  logic         BUSY;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   stim_done = 1'b0;

  down_cnt_tff #(.WIDTH(W)) dut (
    .CK   (CK),
    .CLR  (CLR),
    .E    (E),
    .LD   (LD),
    .D    (D),
    .MODE (MODE),
    .q    (q),
    .TC   (TC),
    .BUSY (BUSY)
  );

  always #5 CK = ~CK;

  task automatic step(input string name, input logic clr, input logic ld, input logic e,
                      input logic mode, input logic [W-1:0] d,
                      input logic [W-1:0] eq, input logic etc, input logic eb);
    exp_t x;
    @(negedge CK);
    CLR  = clr;
    LD   = ld;
    E    = e;
    MODE = mode;
    D    = d;
    x.name = name;
    x.q    = eq;
    x.tc   = etc;
    x.busy = eb;
    sb.push_back(x);
    @(posedge CK);
  endtask

  // Monitor: outputs are valid every cycle, checked 1 time unit after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge CK);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        tests++;
        if (q !== x.q || TC !== x.tc || BUSY !== x.busy) begin
          fails++;
          $display("FAIL %s: got q=%0d TC=%b BUSY=%b, expected q=%0d TC=%b BUSY=%b",
                   x.name, q, TC, BUSY, x.q, x.tc, x.busy);
        end
      end
    end
  end

  initial begin
    // 1. reset, then enable with no load
    step("rst0", 1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
    step("rst1", 1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("idle_en", 0, 0, 1, 0, 4'd0, 4'd0, 0, 0);

    // 2. one-shot from 5
    step("os_ld", 0, 1, 1, 0, 4'd5, 4'd5, 0, 1);
    step("os_4", 0, 0, 1, 0, 4'd0, 4'd4, 0, 1);
    step("os_3", 0, 0, 1, 0, 4'd0, 4'd3, 0, 1);
    step("os_2", 0, 0, 1, 0, 4'd0, 4'd2, 0, 1);
    step("os_1", 0, 0, 1, 0, 4'd0, 4'd1, 0, 1);
    step("os_tc", 0, 0, 1, 0, 4'd0, 4'd0, 1, 0);
    step("os_hold0", 0, 0, 1, 0, 4'd0, 4'd0, 0, 0);
    step("os_hold1", 0, 0, 1, 0, 4'd0, 4'd0, 0, 0);

    // 3. auto-reload from 3, nine enabled edges
    step("ar_ld", 0, 1, 0, 1, 4'd3, 4'd3, 0, 1);
    for (int p = 0; p < 3; p++) begin
      step("ar_2", 0, 0, 1, 1, 4'd0, 4'd2, 0, 1);
      step("ar_1", 0, 0, 1, 1, 4'd0, 4'd1, 0, 1);
      step("ar_tc", 0, 0, 1, 1, 4'd0, 4'd3, 1, 1);
    end

    // 4. enable gating, pattern 1,0,1,0,1,1
    step("eg_ld", 0, 1, 0, 0, 4'd4, 4'd4, 0, 1);
    step("eg_3", 0, 0, 1, 0, 4'd0, 4'd3, 0, 1);
    step("eg_h3", 0, 0, 0, 0, 4'd0, 4'd3, 0, 1);
    step("eg_2", 0, 0, 1, 0, 4'd0, 4'd2, 0, 1);
    step("eg_h2", 0, 0, 0, 0, 4'd0, 4'd2, 0, 1);
    step("eg_1", 0, 0, 1, 0, 4'd0, 4'd1, 0, 1);
    step("eg_tc", 0, 0, 1, 0, 4'd0, 4'd0, 1, 0);

    // 5a. reload mid-count with E high on the load edge
    step("rl_ld9", 0, 1, 0, 0, 4'd9, 4'd9, 0, 1);
    step("rl_8", 0, 0, 1, 0, 4'd0, 4'd8, 0, 1);
    step("rl_7", 0, 0, 1, 0, 4'd0, 4'd7, 0, 1);
    step("rl_6", 0, 0, 1, 0, 4'd0, 4'd6, 0, 1);
    step("rl_ld2", 0, 1, 1, 0, 4'd2, 4'd2, 0, 1);
    step("rl_1", 0, 0, 1, 0, 4'd0, 4'd1, 0, 1);
    step("rl_tc", 0, 0, 1, 0, 4'd0, 4'd0, 1, 0);

    // 5b. load zero
    step("z_ld", 0, 1, 1, 1, 4'd0, 4'd0, 0, 0);
    step("z_en", 0, 0, 1, 1, 4'd0, 4'd0, 0, 0);

    // 5c. full-scale load, TC after exactly 15 enabled edges
    step("fs_ld", 0, 1, 0, 0, 4'd15, 4'd15, 0, 1);
    for (int k = 1; k < 15; k++) step("fs_cnt", 0, 0, 1, 0, 4'd0, 4'(15 - k), 0, 1);
    step("fs_tc", 0, 0, 1, 0, 4'd0, 4'd0, 1, 0);

    // MODE sampled only at the terminal edge
    step("ms_ld", 0, 1, 0, 1, 4'd2, 4'd2, 0, 1);
    step("ms_1", 0, 0, 1, 1, 4'd0, 4'd1, 0, 1);
    step("ms_tc", 0, 0, 1, 0, 4'd0, 4'd0, 1, 0);

    // 6. reset priority over simultaneous LD and E
    step("rp_ld9", 0, 1, 0, 1, 4'd9, 4'd9, 0, 1);
    step("rp_8", 0, 0, 1, 1, 4'd0, 4'd8, 0, 1);
    step("rp_7", 0, 0, 1, 1, 4'd0, 4'd7, 0, 1);
    step("rp_clr", 1, 1, 1, 1, 4'd12, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("rp_idle", 0, 0, 1, 1, 4'd0, 4'd0, 0, 0);

    // period-1 auto-reload: TC on every enabled edge, none while E is low
    step("p1_ld", 0, 1, 0, 1, 4'd1, 4'd1, 0, 1);
    step("p1_tc0", 0, 0, 1, 1, 4'd0, 4'd1, 1, 1);
    step("p1_tc1", 0, 0, 1, 1, 4'd0, 4'd1, 1, 1);
    step("p1_hold", 0, 0, 0, 1, 4'd0, 4'd1, 0, 1);
    step("p1_tc2", 0, 0, 1, 1, 4'd0, 4'd1, 1, 1);

    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CK);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete within time limit");
    $fatal(1);
  end

endmodule
